am_envelope_demod: RTL and testbench

AM envelope demodulator sitting downstream of the narrow bandpass filter in the AM mod/demod chain. It consumes the filter's 16-bit signed output stream over the RTS/RTR handshake, then full-wave rectifies each sample. A single-pole IIR lowpass smooths the rectified signal, and the block decimates by `DECIM`. The recovered envelope is emitted on a registered RTS/RTR output port with lossless backpressure.

---
 rtl/am_envelope_demod.sv | 83 ++++++++
 tb/tb_am_envelope_demod.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_envelope_demod.sv
// AM envelope demodulator: full-wave rectifier, single-pole IIR lowpass and decimator
// between RTS/RTR streams. The output register never drops or overwrites a sample.
module am_envelope_demod #(
  parameter int DECIM     = 4,
  parameter int LPF_SHIFT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din_dat,
  input  logic        din_rts,
  output logic        din_rtr,
  output logic [15:0] dout_dat,
  output logic        dout_rts,
  input  logic        dout_rtr,
  output logic        sat_seen
);
  localparam int AW = 16 + LPF_SHIFT;
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);

  logic [AW-1:0] acc_q, acc_d, acc_upd;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   dout_dat_q, dout_dat_d;
  logic          dout_rts_q, dout_rts_d;
  logic          sat_seen_q, sat_seen_d;
  logic [15:0]   abs_val, mag;
  logic          is_min, in_xfer, out_xfer, cnt_last, load;

  always_comb begin
    is_min  = (din_dat == 16'h8000);
    abs_val = din_dat[15] ? (~din_dat + 16'd1) : din_dat;
    // -32768 has no positive counterpart in 16 bits, so it clamps to full scale.
    mag     = is_min ? 16'h7fff : abs_val;
  end

  assign cnt_last = (cnt_q == CNT_LAST);
  // Only the group-completing sample needs the output register, so only it can stall.
  assign din_rtr  = !(cnt_last && dout_rts_q && !dout_rtr);
  assign in_xfer  = din_rts && din_rtr;
  assign out_xfer = dout_rts_q && dout_rtr;
  assign load     = in_xfer && cnt_last;
  assign acc_upd  = acc_q - (acc_q >> LPF_SHIFT) + AW'(mag);

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_seen_d = sat_seen_q;
    dout_dat_d = dout_dat_q;
    dout_rts_d = dout_rts_q;
    if (in_xfer) begin
      acc_d      = acc_upd;
      cnt_d      = cnt_last ? '0 : cnt_q + CW'(1);
      sat_seen_d = sat_seen_q | is_min;
    end
    // A load on the same edge as a drain wins and keeps the output valid.
    if (load) begin
      dout_dat_d = {1'b0, acc_upd[LPF_SHIFT +: 15]};
      dout_rts_d = 1'b1;
    end else if (out_xfer) begin
      dout_rts_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_seen_q <= 1'b0;
      dout_dat_q <= '0;
      dout_rts_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sat_seen_q <= sat_seen_d;
      dout_dat_q <= dout_dat_d;
      dout_rts_q <= dout_rts_d;
    end
  end

  assign dout_dat = dout_dat_q;
  assign dout_rts = dout_rts_q;
  assign sat_seen = sat_seen_q;
endmodule

// File: tb/tb_am_envelope_demod.sv
// Bench for am_envelope_demod: five instances with different DECIM/LPF_SHIFT, each
// exercised by its own scenario task against a queue-based scoreboard.
module tb_am_envelope_demod;
  localparam int N = 5;

  function automatic int dec_of(input int i);
    case (i)
      0: return 1;
      1: return 4;
      2: return 1;
      3: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int k_of(input int i);
    case (i)
      0: return 4;
      1: return 4;
      2: return 1;
      3: return 4;
      default: return 3;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din_dat  [N];
  logic        din_rts  [N];
  logic        din_rtr  [N];
  logic [15:0] dout_dat [N];
  logic        dout_rts [N];
  logic        dout_rtr [N];
  logic        sat_seen [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    am_envelope_demod #(.DECIM(dec_of(gi)), .LPF_SHIFT(k_of(gi))) u_dut (
      .clk      (clk),
      .reset    (reset),
      .din_dat  (din_dat[gi]),
      .din_rts  (din_rts[gi]),
      .din_rtr  (din_rtr[gi]),
      .dout_dat (dout_dat[gi]),
      .dout_rts (dout_rts[gi]),
      .dout_rtr (dout_rtr[gi]),
      .sat_seen (sat_seen[gi])
    );
  end

  int          passed = 0;
  int          total  = 0;
  int          m_acc, m_cnt;
  logic [15:0] exp_q[$];

  function automatic void model_reset();
    m_acc = 0;
    m_cnt = 0;
    exp_q.delete();
  endfunction

  // Reference: acc <- acc - (acc >> K) + |x|, one output per DECIM accepted inputs.
  function automatic void model_in(input int idx, input logic [15:0] x);
    int a;
    if (x == 16'h8000) a = 32767;
    else if (x[15])    a = 65536 - int'(x);
    else               a = int'(x);
    m_acc = m_acc - (m_acc >> k_of(idx)) + a;
    m_cnt++;
    if (m_cnt == dec_of(idx)) begin
      m_cnt = 0;
      exp_q.push_back(16'(m_acc >> k_of(idx)));
    end
  endfunction

  task automatic step(input int idx, input logic rts, input logic [15:0] dat, input logic rtr,
                      output bit in_x, output bit out_x, output logic [15:0] out_d);
    @(negedge clk);
    din_rts[idx]  = rts;
    din_dat[idx]  = dat;
    dout_rtr[idx] = rtr;
    #1;
    in_x  = rts && din_rtr[idx];
    out_x = dout_rts[idx] && rtr;
    out_d = dout_dat[idx];
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      din_rts[i]  = 1'b0;
      dout_rtr[i] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      reset = (c < 10);
      for (int i = 0; i < N; i++) begin
        din_rts[i]  = (c < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
        din_dat[i]  = (c == 3) ? 16'h8000 : 16'($urandom);
        dout_rtr[i] = (c < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        total++;
        if (dout_rts[i] !== 1'b0) $display("FAIL reset_dout_rts inst=%0d cyc=%0d got=%b want=0", i, c, dout_rts[i]);
        else passed++;
        total++;
        if (dout_dat[i] !== 16'd0) $display("FAIL reset_dout_dat inst=%0d cyc=%0d got=%0d want=0", i, c, dout_dat[i]);
        else passed++;
        total++;
        if (sat_seen[i] !== 1'b0) $display("FAIL reset_sat_seen inst=%0d cyc=%0d got=%b want=0", i, c, sat_seen[i]);
        else passed++;
        total++;
        if (din_rtr[i] !== 1'b1) $display("FAIL reset_din_rtr inst=%0d cyc=%0d got=%b want=1", i, c, din_rtr[i]);
        else passed++;
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_impulse();
    bit in_x, out_x;
    logic [15:0] od, e;
    int sent = 0;
    int got[$];
    bit mono = 1'b1;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      step(0, sent < 20, (sent == 0) ? 16'd1600 : 16'd0, 1'b1, in_x, out_x, od);
      if (out_x) begin
        got.push_back(int'(od));
        total++;
        if (exp_q.size() == 0) $display("FAIL impulse_extra got=%0d want=none", od);
        else begin
          e = exp_q.pop_front();
          if (od !== e) $display("FAIL impulse_data idx=%0d got=%0d want=%0d", got.size() - 1, od, e);
          else passed++;
        end
      end
      if (in_x) begin model_in(0, din_dat[0]); sent++; end
    end
    total++;
    if (got.size() != 20) $display("FAIL impulse_count got=%0d want=20", got.size());
    else passed++;
    total++;
    if (got[0] != 100) $display("FAIL impulse_first got=%0d want=100", got[0]);
    else passed++;
    total++;
    if (got[1] != 93) $display("FAIL impulse_second got=%0d want=93", got[1]);
    else passed++;
    for (int i = 1; i < got.size(); i++) if (got[i] > got[i-1]) mono = 1'b0;
    total++;
    if (!mono) $display("FAIL impulse_monotonic got=rising want=non-increasing");
    else passed++;
    $display("test_impulse outputs=%0d first=%0d second=%0d", got.size(), got[0], got[1]);
  endtask

  task automatic test_back_to_back();
    bit in_x, out_x;
    logic [15:0] od, e;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      step(0, c < 12, 16'(1000 * (c + 1)), 1'b1, in_x, out_x, od);
      if (c >= 1) begin
        total++;
        if (!out_x) $display("FAIL b2b_bubble cyc=%0d got=0 want=1", c);
        else passed++;
      end
      if (out_x) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra got=%0d want=none", od);
        else begin
          e = exp_q.pop_front();
          if (od !== e) $display("FAIL b2b_data cyc=%0d got=%0d want=%0d", c, od, e);
          else passed++;
        end
      end
      if (in_x) model_in(0, din_dat[0]);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_convergence();
    bit in_x, out_x;
    logic [15:0] od, e;
    logic [15:0] pos = 16'd10000;
    logic [15:0] neg;
    int sent = 0;
    int got[$];
    neg = ~pos + 16'd1;
    do_reset();
    for (int c = 0; c < 1000 && (sent < 400 || c < sent + 4); c++) begin
      step(1, sent < 400, sent[0] ? neg : pos, 1'b1, in_x, out_x, od);
      if (out_x) begin
        got.push_back(int'(od));
        total++;
        if (exp_q.size() == 0) $display("FAIL conv_extra got=%0d want=none", od);
        else begin
          e = exp_q.pop_front();
          if (od !== e) $display("FAIL conv_data idx=%0d got=%0d want=%0d", got.size() - 1, od, e);
          else passed++;
        end
      end
      if (in_x) begin model_in(1, din_dat[1]); sent++; end
    end
    total++;
    if (got.size() != 100) $display("FAIL conv_count got=%0d want=100", got.size());
    else passed++;
    for (int i = 90; i < 100; i++) begin
      total++;
      if (got[i] != 10000) $display("FAIL conv_final idx=%0d got=%0d want=10000", i, got[i]);
      else passed++;
    end
    total++;
    if (sat_seen[1] !== 1'b0) $display("FAIL conv_sat_seen got=%b want=0", sat_seen[1]);
    else passed++;
    $display("test_convergence outputs=%0d", got.size());
  endtask

  task automatic test_saturation();
    bit in_x, out_x;
    logic [15:0] od;
    int n_out = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step(2, c == 0, (c == 0) ? 16'h8000 : 16'd0, 1'b1, in_x, out_x, od);
      if (out_x) begin
        n_out++;
        total++;
        if (od !== 16'd16383) $display("FAIL sat_output got=%0d want=16383", od);
        else passed++;
      end
      #1;
      total++;
      if (sat_seen[2] !== 1'b1) $display("FAIL sat_sticky cyc=%0d got=%b want=1", c, sat_seen[2]);
      else passed++;
    end
    total++;
    if (n_out != 1) $display("FAIL sat_count got=%0d want=1", n_out);
    else passed++;
    do_reset();
    #1;
    total++;
    if (sat_seen[2] !== 1'b0) $display("FAIL sat_clear got=%b want=0", sat_seen[2]);
    else passed++;
    $display("test_saturation outputs=%0d", n_out);
  endtask

  task automatic test_backpressure();
    bit in_x, out_x;
    logic [15:0] od, e, held, dat;
    int acc_n = 0;
    int n_out = 0;
    bit have_held = 1'b0;
    do_reset();
    dat = 16'($urandom);
    for (int c = 0; c < 40; c++) begin
      step(3, (c < 20) || (acc_n < 14), dat, c >= 20, in_x, out_x, od);
      if (c < 20 && acc_n >= 3) begin
        total++;
        if (in_x) $display("FAIL bp_din_rtr cyc=%0d got=1 want=0", c);
        else passed++;
        if (!have_held) begin held = od; have_held = 1'b1; end
        else begin
          total++;
          if (od !== held) $display("FAIL bp_hold cyc=%0d got=%0d want=%0d", c, od, held);
          else passed++;
        end
      end
      if (out_x) begin
        n_out++;
        total++;
        if (exp_q.size() == 0) $display("FAIL bp_extra got=%0d want=none", od);
        else begin
          e = exp_q.pop_front();
          if (od !== e) $display("FAIL bp_data idx=%0d got=%0d want=%0d", n_out - 1, od, e);
          else passed++;
        end
      end
      if (in_x) begin model_in(3, dat); acc_n++; dat = 16'($urandom); end
      if (c == 19) begin
        total++;
        if (acc_n != 3) $display("FAIL bp_accepted got=%0d want=3", acc_n);
        else passed++;
      end
    end
    total++;
    if (n_out != 7 || exp_q.size() != 0) $display("FAIL bp_count got=%0d left=%0d want=7 left=0", n_out, exp_q.size());
    else passed++;
    $display("test_backpressure accepted=%0d outputs=%0d", acc_n, n_out);
  endtask

  task automatic test_random();
    bit in_x, out_x;
    logic [15:0] od, e;
    int sent = 0;
    int n_out = 0;
    int c;
    do_reset();
    for (c = 0; c < 20000 && sent < 2000; c++) begin
      step(4, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), in_x, out_x, od);
      if (out_x) begin
        n_out++;
        total++;
        if (exp_q.size() == 0) $display("FAIL rand_extra got=%0d want=none", od);
        else begin
          e = exp_q.pop_front();
          if (od !== e) $display("FAIL rand_data idx=%0d got=%0d want=%0d", n_out - 1, od, e);
          else passed++;
        end
      end
      if (in_x) begin model_in(4, din_dat[4]); sent++; end
    end
    for (int d = 0; d < 4; d++) begin
      step(4, 1'b0, 16'd0, 1'b1, in_x, out_x, od);
      if (out_x) begin
        n_out++;
        total++;
        if (exp_q.size() == 0) $display("FAIL rand_extra got=%0d want=none", od);
        else begin
          e = exp_q.pop_front();
          if (od !== e) $display("FAIL rand_data idx=%0d got=%0d want=%0d", n_out - 1, od, e);
          else passed++;
        end
      end
    end
    total++;
    if (sent != 2000) $display("FAIL rand_budget got=%0d want=2000 inputs", sent);
    else passed++;
    total++;
    if (n_out != 666 || exp_q.size() != 0) $display("FAIL rand_count got=%0d left=%0d want=666 left=0", n_out, exp_q.size());
    else passed++;
    $display("test_random cycles=%0d inputs=%0d outputs=%0d", c, sent, n_out);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      din_rts[i]  = 1'b0;
      din_dat[i]  = 16'd0;
      dout_rtr[i] = 1'b1;
    end
    model_reset();
    test_reset();
    test_impulse();
    test_back_to_back();
    test_convergence();
    test_saturation();
    test_backpressure();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
